// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and constants for the two-source packet arbiter
package axis_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    TERM  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // Error beat that terminates a stalled packet: empty keep, closes the frame.
  localparam logic ERR_TDATA_BIT = 1'b0;
  localparam logic ERR_TKEEP_BIT = 1'b0;
  localparam logic ERR_TLAST     = 1'b1;

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// rtl/axis_pkt_arbiter_if.sv - AXI-Stream style link bundle with source and sink views
interface axis_pkt_arbiter_if #(
  parameter int DATA_W = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry registered slice, one cycle latency, full throughput
module axis_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast
);
  logic                skid_valid;
  logic [DATA_W-1:0]   skid_tdata;
  logic [DATA_W/8-1:0] skid_tkeep;
  logic                skid_tlast;
  logic                push;

  // The skid entry only fills behind a valid head, so it alone marks "full".
  assign s_tready = !skid_valid;
  assign push     = s_tvalid && !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tlast    <= 1'b0;
      skid_valid <= 1'b0;
      skid_tdata <= '0;
      skid_tkeep <= '0;
      skid_tlast <= 1'b0;
    end else begin
      if (!m_tvalid || m_tready) begin
        if (skid_valid) begin
          m_tvalid   <= 1'b1;
          m_tdata    <= skid_tdata;
          m_tkeep    <= skid_tkeep;
          m_tlast    <= skid_tlast;
          skid_valid <= 1'b0;
        end else begin
          m_tvalid <= push;
          if (push) begin
            m_tdata <= s_tdata;
            m_tkeep <= s_tkeep;
            m_tlast <= s_tlast;
          end
        end
      end else if (push) begin
        skid_valid <= 1'b1;
        skid_tdata <= s_tdata;
        skid_tkeep <= s_tkeep;
        skid_tlast <= s_tlast;
      end
    end
  end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - whole-packet arbiter for two streams onto one link
module axis_pkt_arbiter #(
  parameter int DATA_W = 32,
  parameter int TMO_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                axis_clk,
  input  logic                rst_n,
  axis_pkt_arbiter_if.slave   s0,
  axis_pkt_arbiter_if.slave   s1,
  axis_pkt_arbiter_if.master  m,
  input  logic                cfg_enable,
  input  logic                cfg_fixed_prio,
  input  logic [TMO_W-1:0]    cfg_timeout,
  output logic                grant_id,
  output logic                busy,
  output logic                tmo_pulse,
  output logic [CNT_W-1:0]    pkt_cnt0,
  output logic [CNT_W-1:0]    pkt_cnt1
);
  import axis_arb_pkg::*;

  localparam int KEEP_W = DATA_W / 8;

  arb_state_e        state, state_nxt;
  logic              rr_prio;
  logic              seen_beat;
  logic [TMO_W-1:0]  wdt;
  logic [TMO_W:0]    wdt_inc;

  logic              winner, grant_start;
  logic              g_valid, g_last, g_ready, accept, tmo_fire, pkt_done;
  logic [DATA_W-1:0] g_tdata;
  logic [KEEP_W-1:0] g_tkeep;

  logic              buf_valid, buf_ready, buf_tlast;
  logic [DATA_W-1:0] buf_tdata;
  logic [KEEP_W-1:0] buf_tkeep;

  always_comb begin
    winner = SRC0;
    if (s0.tvalid && s1.tvalid) winner = cfg_fixed_prio ? SRC0 : rr_prio;
    else if (s1.tvalid)         winner = SRC1;
  end

  assign grant_start = (state == IDLE) && cfg_enable && (s0.tvalid || s1.tvalid);

  assign g_valid = (grant_id == SRC1) ? s1.tvalid : s0.tvalid;
  assign g_last  = (grant_id == SRC1) ? s1.tlast  : s0.tlast;
  assign g_tdata = (grant_id == SRC1) ? s1.tdata  : s0.tdata;
  assign g_tkeep = (grant_id == SRC1) ? s1.tkeep  : s0.tkeep;
  assign accept  = g_valid && g_ready;

  // Stall only counts once the packet has started; a tlast accept can never fire it since it needs !g_valid.
  assign wdt_inc  = {1'b0, wdt} + (TMO_W+1)'(1);
  assign tmo_fire = (state == PASS) && seen_beat && !g_valid &&
                    (cfg_timeout != '0) && (wdt_inc >= {1'b0, cfg_timeout});

  assign pkt_done = ((state == PASS) && accept && g_last) || ((state == TERM) && buf_ready);

  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (grant_start) state_nxt = PASS;
      PASS: begin
        if (accept && g_last) state_nxt = IDLE;
        else if (tmo_fire)    state_nxt = TERM;
      end
      TERM:  if (buf_ready) state_nxt = (accept && g_last) ? IDLE : DRAIN;
      DRAIN: if (accept && g_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    g_ready   = 1'b0;
    buf_valid = 1'b0;
    buf_tdata = g_tdata;
    buf_tkeep = g_tkeep;
    buf_tlast = g_last;
    tmo_pulse = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      PASS: begin
        g_ready   = buf_ready;
        buf_valid = g_valid;
        tmo_pulse = tmo_fire;
      end
      TERM: begin
        g_ready   = buf_ready;
        buf_valid = 1'b1;
        buf_tdata = {DATA_W{ERR_TDATA_BIT}};
        buf_tkeep = {KEEP_W{ERR_TKEEP_BIT}};
        buf_tlast = ERR_TLAST;
      end
      DRAIN:   g_ready = 1'b1;
      default: g_ready = 1'b0;
    endcase
  end

  assign s0.tready = g_ready && (grant_id == SRC0);
  assign s1.tready = g_ready && (grant_id == SRC1);

  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id  <= SRC0;
      rr_prio   <= SRC0;
      seen_beat <= 1'b0;
      wdt       <= '0;
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
    end else begin
      if (grant_start) begin
        grant_id  <= winner;
        rr_prio   <= ~winner;
        seen_beat <= 1'b0;
        wdt       <= '0;
      end else if (state == PASS) begin
        if (accept) begin
          seen_beat <= 1'b1;
          wdt       <= '0;
        end else if (seen_beat && !g_valid) begin
          wdt <= wdt_inc[TMO_W-1:0];
        end
      end
      if (pkt_done) begin
        if (grant_id == SRC1) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
        else                  pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      end
    end
  end

  axis_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk      (axis_clk),
    .rst_n    (rst_n),
    .s_tvalid (buf_valid),
    .s_tready (buf_ready),
    .s_tdata  (buf_tdata),
    .s_tkeep  (buf_tkeep),
    .s_tlast  (buf_tlast),
    .m_tvalid (m.tvalid),
    .m_tready (m.tready),
    .m_tdata  (m.tdata),
    .m_tkeep  (m.tkeep),
    .m_tlast  (m.tlast)
  );
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - self-checking bench for axis_pkt_arbiter
module tb_axis_pkt_arbiter;
  localparam int DATA_W = 32;
  localparam int TMO_W  = 16;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    int          idle;
  } beat_t;

  typedef struct {
    logic fixed;
    logic r0;
    logic r1;
    logic exp_grant;
  } arb_vec_t;

  logic             axis_clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_enable, cfg_fixed_prio;
  logic [TMO_W-1:0] cfg_timeout;
  logic             grant_id, busy, tmo_pulse;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  always #5 axis_clk = ~axis_clk;

  axis_pkt_arbiter_if #(.DATA_W(DATA_W)) s0_if ();
  axis_pkt_arbiter_if #(.DATA_W(DATA_W)) s1_if ();
  axis_pkt_arbiter_if #(.DATA_W(DATA_W)) m_if ();

  axis_pkt_arbiter #(.DATA_W(DATA_W), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .axis_clk       (axis_clk),
    .rst_n          (rst_n),
    .s0             (s0_if),
    .s1             (s1_if),
    .m              (m_if),
    .cfg_enable     (cfg_enable),
    .cfg_fixed_prio (cfg_fixed_prio),
    .cfg_timeout    (cfg_timeout),
    .grant_id       (grant_id),
    .busy           (busy),
    .tmo_pulse      (tmo_pulse),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
  );

  beat_t q0[$], q1[$], sb[$];
  arb_vec_t vec[12];
  int errors = 0, checks = 0;
  int tmo_seen, tmo_idle, occ, exp_cnt0, exp_cnt1;
  logic bp_chk = 1'b0, lat_chk = 1'b0, lat_pend = 1'b0;
  logic [31:0] lat_data;
  logic fire0, fire1, mfire;
  logic prev_stall = 1'b0;
  logic [36:0] prev_beat;
  logic bp_pat[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic present();
    s0_if.tvalid = (q0.size() > 0) && (q0[0].idle == 0);
    s0_if.tdata  = (q0.size() > 0) ? q0[0].data : 32'h0;
    s0_if.tkeep  = (q0.size() > 0) ? q0[0].keep : 4'h0;
    s0_if.tlast  = (q0.size() > 0) ? q0[0].last : 1'b0;
    s1_if.tvalid = (q1.size() > 0) && (q1[0].idle == 0);
    s1_if.tdata  = (q1.size() > 0) ? q1[0].data : 32'h0;
    s1_if.tkeep  = (q1.size() > 0) ? q1[0].keep : 4'h0;
    s1_if.tlast  = (q1.size() > 0) ? q1[0].last : 1'b0;
  endtask

  task automatic tick();
    beat_t e;
    @(negedge axis_clk);
    fire0 = s0_if.tvalid && s0_if.tready;
    fire1 = s1_if.tvalid && s1_if.tready;
    mfire = m_if.tvalid && m_if.tready;
    if (prev_stall) begin
      chk("hold_valid", 64'(m_if.tvalid), 64'd1);
      chk("hold_beat", 64'({m_if.tdata, m_if.tkeep, m_if.tlast}), 64'(prev_beat));
    end
    prev_stall = m_if.tvalid && !m_if.tready;
    prev_beat  = {m_if.tdata, m_if.tkeep, m_if.tlast};
    if (mfire) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", m_if.tdata);
      end else begin
        e = sb.pop_front();
        chk("out_beat", 64'({m_if.tdata, m_if.tkeep, m_if.tlast}), 64'({e.data, e.keep, e.last}));
      end
    end
    if (lat_pend) begin
      chk("latency", 64'({m_if.tvalid, m_if.tdata}), 64'({1'b1, lat_data}));
      lat_pend = 1'b0;
    end
    if (lat_chk && fire0) begin
      lat_pend = 1'b1;
      lat_data = s0_if.tdata;
    end
    if (tmo_pulse) begin
      tmo_seen++;
      tmo_idle = (q0.size() > 0) ? q0[0].idle : -1;
    end
    if (bp_chk) begin
      if (occ >= 2) chk("s0_tready_full", 64'(s0_if.tready), 64'd0);
      occ = occ + int'(fire0) - int'(mfire);
    end
    @(posedge axis_clk);
    #1;
    if (fire0) void'(q0.pop_front());
    else if (q0.size() > 0 && q0[0].idle > 0) q0[0].idle = q0[0].idle - 1;
    if (fire1) void'(q1.pop_front());
    else if (q1.size() > 0 && q1[0].idle > 0) q1[0].idle = q1[0].idle - 1;
    present();
  endtask

  task automatic send(input int src, input logic [31:0] base, input int n,
                      input int gap_at, input int gap, input logic to_sb);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + 32'(i);
      b.keep = 4'hF;
      b.last = (i == n - 1);
      b.idle = (i == gap_at) ? gap : 0;
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
      if (to_sb) begin
        b.idle = 0;
        sb.push_back(b);
      end
    end
    present();
  endtask

  task automatic expect_pkt(input logic [31:0] base, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + 32'(i);
      b.keep = 4'hF;
      b.last = (i == n - 1);
      b.idle = 0;
      sb.push_back(b);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && !busy && !m_if.tvalid) break;
      tick();
    end
    if (k == budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", name, sb.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    sb.delete();
    prev_stall = 1'b0;
    lat_pend   = 1'b0;
    present();
    @(posedge axis_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    vec[0]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vec[5]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vec[10] = '{1'b1, 1'b0, 1'b1, 1'b1};
    vec[11] = '{1'b0, 1'b1, 1'b1, 1'b0};

    cfg_enable     = 1'b1;
    cfg_fixed_prio = 1'b0;
    cfg_timeout    = '0;
    m_if.tready    = 1'b1;
    present();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge axis_clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_tmo", 64'(tmo_pulse), 64'd0);
    chk("rst_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("rst_cnt1", 64'(pkt_cnt1), 64'd0);
    chk("rst_mvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_s0_tready", 64'(s0_if.tready), 64'd0);
    rst_n = 1'b1;
    tick();

    // Arbitration table: each row is one simultaneous request; the loser withdraws after the grant.
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    for (int i = 0; i < 12; i++) begin
      cfg_fixed_prio = vec[i].fixed;
      if (vec[i].r0) send(0, 32'hA0 + 32'(i), 1, -1, 0, 1'b0);
      if (vec[i].r1) send(1, 32'hB0 + 32'(i), 1, -1, 0, 1'b0);
      tick();
      chk($sformatf("arb_grant_%0d", i), 64'(grant_id), 64'(vec[i].exp_grant));
      chk($sformatf("arb_busy_%0d", i), 64'(busy), 64'd1);
      if (vec[i].exp_grant) begin
        q0.delete();
        expect_pkt(32'hB0 + 32'(i), 1);
        exp_cnt1++;
      end else begin
        q1.delete();
        expect_pkt(32'hA0 + 32'(i), 1);
        exp_cnt0++;
      end
      present();
      wait_idle($sformatf("arb_row_%0d", i), 20);
    end
    chk("arb_cnt0", 64'(pkt_cnt0), 64'(exp_cnt0));
    chk("arb_cnt1", 64'(pkt_cnt1), 64'(exp_cnt1));

    cfg_enable = 1'b0;
    send(0, 32'h77, 1, -1, 0, 1'b1);
    repeat (4) tick();
    chk("disabled_no_grant", 64'(busy), 64'd0);
    cfg_enable = 1'b1;
    wait_idle("enable", 20);

    do_reset();
    lat_chk = 1'b1;
    send(0, 32'h11, 4, -1, 0, 1'b1);
    wait_idle("single", 40);
    lat_chk = 1'b0;
    chk("single_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("single_grant", 64'(grant_id), 64'd0);

    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      cfg_fixed_prio = mode[0];
      for (int p = 0; p < 3; p++) begin
        send(0, 32'h100 + 32'(p * 16), 2, -1, 0, 1'b0);
        send(1, 32'h200 + 32'(p * 16), 2, -1, 0, 1'b0);
      end
      if (mode == 0) begin
        for (int p = 0; p < 3; p++) begin
          expect_pkt(32'h100 + 32'(p * 16), 2);
          expect_pkt(32'h200 + 32'(p * 16), 2);
        end
      end else begin
        for (int p = 0; p < 3; p++) expect_pkt(32'h100 + 32'(p * 16), 2);
        for (int p = 0; p < 3; p++) expect_pkt(32'h200 + 32'(p * 16), 2);
      end
      wait_idle($sformatf("contend_%0d", mode), 200);
      chk($sformatf("contend_cnt0_%0d", mode), 64'(pkt_cnt0), 64'd3);
      chk($sformatf("contend_cnt1_%0d", mode), 64'(pkt_cnt1), 64'd3);
    end
    cfg_fixed_prio = 1'b0;

    do_reset();
    occ    = 0;
    bp_chk = 1'b1;
    send(0, 32'h40, 8, -1, 0, 1'b1);
    for (int k = 0; k < 100 && (q0.size() > 0 || sb.size() > 0); k++) begin
      m_if.tready = bp_pat[k % 4];
      tick();
    end
    m_if.tready = 1'b1;
    wait_idle("backpressure", 40);
    bp_chk = 1'b0;
    chk("bp_cnt0", 64'(pkt_cnt0), 64'd1);

    // Timeout: two beats, five stalled cycles, then three beats that must be drained.
    do_reset();
    cfg_timeout = 16'd5;
    tmo_seen    = 0;
    tmo_idle    = -1;
    send(0, 32'h21, 5, 2, 5, 1'b0);
    send(1, 32'h31, 1, -1, 0, 1'b0);
    expect_pkt(32'h21, 2);
    sb[1].last = 1'b0;
    sb.push_back('{32'h0, 4'h0, 1'b1, 0});
    expect_pkt(32'h31, 1);
    wait_idle("timeout", 100);
    chk("tmo_count", 64'(tmo_seen), 64'd1);
    chk("tmo_at_5th_stall", 64'(tmo_idle), 64'd1);
    chk("tmo_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("tmo_cnt1", 64'(pkt_cnt1), 64'd1);
    chk("tmo_next_grant", 64'(grant_id), 64'd1);
    cfg_timeout = '0;

    // Asynchronous reset in the middle of beat 2 of an s0 packet.
    send(0, 32'h51, 4, -1, 0, 1'b1);
    for (int k = 0; k < 20 && q0.size() > 2; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mvalid", 64'(m_if.tvalid), 64'd0);
    chk("midrst_mdata", 64'(m_if.tdata), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("midrst_cnt1", 64'(pkt_cnt1), 64'd0);
    chk("midrst_s0_tready", 64'(s0_if.tready), 64'd0);
    q0.delete();
    q1.delete();
    sb.delete();
    prev_stall = 1'b0;
    present();
    @(posedge axis_clk);
    #1;
    rst_n = 1'b1;
    send(1, 32'h61, 2, -1, 0, 1'b1);
    wait_idle("post_reset", 40);
    chk("post_rst_cnt1", 64'(pkt_cnt1), 64'd1);
    chk("post_rst_cnt0", 64'(pkt_cnt0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
